// File: rtl/uart_in_fifo_if.sv
// Byte stream bundle between the host register block, the input FIFO and the serial receiver.
// The level port is carried only when UART_IN_FIFO_LEVEL_EN is defined.
interface uart_in_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
);
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               flush;
`ifdef UART_IN_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0] level;
`endif

    // Valid/ready on both sides: a beat transfers on an edge where valid && ready;
    // the producer holds valid and data stable until that edge, and ready never
    // depends combinationally on the opposite side of the FIFO.
`ifdef UART_IN_FIFO_LEVEL_EN
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, level
    );
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, level
    );
`else
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/uart_in_fifo.sv
// Register-array byte FIFO absorbing host write bursts ahead of the emulated serial receiver.
// Optional occupancy output: define UART_IN_FIFO_LEVEL_EN.
module uart_in_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_in_fifo_if.slave    fifo_if
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q,  count_d;
    logic             push, pop;

    assign fifo_if.in_ready  = (count_q != FULL_CNT);
    assign fifo_if.out_valid = (count_q != '0);
    assign fifo_if.out_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign push = fifo_if.in_valid  && fifo_if.in_ready;
    assign pop  = fifo_if.out_valid && fifo_if.out_ready;

    // Flush wins over any handshake that happens to complete in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
            if (push && !pop)      count_d = count_q + ONE;
            else if (pop && !push) count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; out_data is only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (push && !fifo_if.flush) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= fifo_if.in_data;
        end
    end

`ifdef UART_IN_FIFO_LEVEL_EN
    assign fifo_if.level = count_q;
`endif

endmodule

// File: tb/tb_uart_in_fifo.sv
// Bench for uart_in_fifo: vector table for short handshake cases, hand-written sequences
// for fill, wrap-around streaming, flush and reset, all checked against a queue model.
module tb_uart_in_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int WIDTH      = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_in_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) bus ();

    uart_in_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             out_ready;
        logic             flush;
        logic             exp_out_valid;
        logic [WIDTH-1:0] exp_out_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, compare against the model, update the model, take the edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        logic m_push, m_pop;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
`ifdef UART_IN_FIFO_LEVEL_EN
        chk("level", 32'(bus.level), 32'(exp_q.size()));
`endif
        m_push = v && (exp_q.size() != DEPTH);
        m_pop  = r && (exp_q.size() != 0);
        if (f) begin
            exp_q.delete();
        end else begin
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10};
        vecs[3] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'h20};
        vecs[4] = '{1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h20};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h30};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        #12;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
            if (vecs[i].exp_out_valid)
                chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_out_data));
        end
        idle();

        // Fill to DEPTH, hold 0xFF against a full FIFO, then pop once while it is still offered.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        #1;
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
`ifdef UART_IN_FIFO_LEVEL_EN
        chk("full level", 32'(bus.level), 32'd16);
`endif
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        #1;
        chk("pop at full in_ready", 32'(bus.in_ready), 32'd1);
        chk("pop at full head", 32'(bus.out_data), 32'h01);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        #1;
        chk("refill in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drained", 32'(exp_q.size()), 32'd0);
        idle();

        // Sustained push+pop at occupancy 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        #1;
        chk("stream out_valid", 32'(bus.out_valid), 32'd1);
`ifdef UART_IN_FIFO_LEVEL_EN
        chk("stream level", 32'(bus.level), 32'd3);
`endif
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Flush at count 5 with a concurrent push: the pushed byte must never appear.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
`ifdef UART_IN_FIFO_LEVEL_EN
        chk("flush level", 32'(bus.level), 32'd0);
`endif
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        #1;
        chk("post flush head", 32'(bus.out_data), 32'h66);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Asynchronous reset in the middle of a cycle with data held.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
`ifdef UART_IN_FIFO_LEVEL_EN
        chk("async rst level", 32'(bus.level), 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
